// File: rtl/inst_queue_pkg.sv
// Shared constants and the queue entry layout {pred, pc, inst}, which the dispatcher reuses.
package inst_queue_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 32;
    localparam logic [INST_W-1:0] NOP_INST = 32'h00000013;

    typedef struct packed {
        logic              pred;
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } iq_entry_t;

    localparam int ENTRY_W = $bits(iq_entry_t);

endpackage

// File: rtl/inst_queue_ram.sv
// Entry storage: DEPTH x ENTRY_W register array, one synchronous write port.
// Latency: write visible on the cycle after the write edge; the read port is asynchronous.
// Backpressure: none; the caller owns all pointer and flow-control logic.
module inst_queue_ram
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4,
    parameter int W     = ENTRY_W
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [W-1:0]     wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [W-1:0]     rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_queue.sv
// Fetch-to-dispatch circular instruction queue; optional same-cycle bypass under INST_QUEUE_BYPASS_EN.
// Latency: 1 cycle push-to-visible (0 cycles on bypass when empty); head outputs are combinational.
// Backpressure: IF_full holds the producer; rdy=0 freezes all state; flush clears everything.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic              IF_push,
    input  logic [INST_W-1:0] IF_inst,
    input  logic [ADDR_W-1:0] IF_pc,
    input  logic              IF_pred_jump,
    output logic              IF_full,
    output logic              ID_valid,
    output logic [INST_W-1:0] ID_inst,
    output logic [ADDR_W-1:0] ID_pc,
    output logic              ID_pred_jump,
    input  logic              ID_pop
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;
    iq_entry_t        wr_ent;
    iq_entry_t        rd_ent;
    logic             empty;
    logic             bypass;
    logic             push_ok;
    logic             pop_ok;
    logic             wr_en;
    logic             adv_head;

    assign empty   = (count == '0);
    assign IF_full = (count == FULL_CNT);

`ifdef INST_QUEUE_BYPASS_EN
    // Gated by rdy so a frozen queue also keeps its outputs frozen.
    assign bypass = empty & IF_push & rdy & ~flush;
`else
    assign bypass = 1'b0;
`endif

    assign ID_valid = ~empty | bypass;
    assign push_ok  = IF_push & ~IF_full;
    assign pop_ok   = ID_pop & ID_valid;

    // A bypassed entry that is popped in the same cycle never touches storage.
    assign wr_en    = rdy & ~flush & push_ok & ~(bypass & ID_pop);
    assign adv_head = pop_ok & ~bypass;

    assign wr_ent = {IF_pred_jump, IF_pc, IF_inst};

    inst_queue_ram #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .W     (ENTRY_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (tail),
        .wdata (wr_ent),
        .raddr (head),
        .rdata (rd_ent)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy) begin
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (wr_en) begin
                    tail <= tail + PTR_W'(1);
                end
                if (adv_head) begin
                    head <= head + PTR_W'(1);
                end
                case ({wr_en, adv_head})
                    2'b10:   count <= count + (PTR_W + 1)'(1);
                    2'b01:   count <= count - (PTR_W + 1)'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    always_comb begin
        ID_inst      = '0;
        ID_pc        = '0;
        ID_pred_jump = 1'b0;
        if (bypass) begin
            ID_inst      = IF_inst;
            ID_pc        = IF_pc;
            ID_pred_jump = IF_pred_jump;
        end else if (!empty) begin
            ID_inst      = rd_ent.inst;
            ID_pc        = rd_ent.pc;
            ID_pred_jump = rd_ent.pred;
        end
    end

endmodule
